// File: rtl/axil_master_bridge.sv
// Bridges the core's single-outstanding load/store request port onto an
// AXI4-Lite master: one read or write in flight, one-cycle completion pulse.
module axil_master_bridge #(
  parameter int         DATA_WIDTH = 32,
  parameter int         ADDR_WIDTH = 32,
  parameter int         STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [2:0] PROT       = 3'b000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [STRB_WIDTH-1:0] req_wstrb,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_awvalid, r_wvalid, r_arvalid;
  logic                  r_aw_done, r_w_done, r_we, r_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [STRB_WIDTH-1:0] r_wstrb;

  logic                  w_awvalid_nxt, w_wvalid_nxt, w_arvalid_nxt;
  logic                  w_aw_done_nxt, w_w_done_nxt, w_err_nxt;
  logic [DATA_WIDTH-1:0] w_rdata_nxt;
  logic                  w_accept, w_aw_hs, w_w_hs, w_b_hs, w_r_hs, w_ar_hs;
  logic                  w_unused;

  assign req_ready = rstn && (r_state == IDLE);
  assign w_accept  = req_valid && req_ready;
  assign w_aw_hs   = r_awvalid && m_axil_awready;
  assign w_w_hs    = r_wvalid && m_axil_wready;
  assign w_ar_hs   = r_arvalid && m_axil_arready;
  assign w_b_hs    = m_axil_bvalid && m_axil_bready;
  assign w_r_hs    = m_axil_rvalid && m_axil_rready;

  // Only bit 1 of a response (SLVERR/DECERR) matters to the core.
  assign w_unused  = ^{m_axil_bresp[0], m_axil_rresp[0], w_ar_hs};

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    w_state_nxt   = r_state;
    w_aw_done_nxt = r_aw_done || w_aw_hs;
    w_w_done_nxt  = r_w_done || w_w_hs;
    w_err_nxt     = r_err;
    w_rdata_nxt   = r_rdata;
    unique case (r_state)
      IDLE: if (w_accept) begin
        w_state_nxt   = req_we ? WRITE : READ;
        w_aw_done_nxt = 1'b0;
        w_w_done_nxt  = 1'b0;
      end
      WRITE: if (w_b_hs) begin
        w_state_nxt = DONE;
        w_err_nxt   = m_axil_bresp[1];
      end
      READ: if (w_r_hs) begin
        w_state_nxt = DONE;
        w_err_nxt   = m_axil_rresp[1];
        w_rdata_nxt = m_axil_rdata;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // Valids are registered: raised on entry, dropped after their handshake.
    w_awvalid_nxt = (w_state_nxt == WRITE) && !w_aw_done_nxt;
    w_wvalid_nxt  = (w_state_nxt == WRITE) && !w_w_done_nxt;
    w_arvalid_nxt = (w_state_nxt == READ) &&
                    ((r_state == IDLE) || (r_arvalid && !m_axil_arready));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: reset is synchronous; every register here is cleared on a clock edge with rstn low.
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
    end else begin
      r_awvalid <= w_awvalid_nxt;
      r_wvalid  <= w_wvalid_nxt;
      r_arvalid <= w_arvalid_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
      r_err     <= w_err_nxt;
      r_rdata   <= w_rdata_nxt;
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_wstrb <= req_wstrb;
      end
    end
  end

  assign m_axil_awaddr  = r_addr;
  assign m_axil_araddr  = r_addr;
  assign m_axil_awprot  = PROT;
  assign m_axil_arprot  = PROT;
  assign m_axil_awvalid = r_awvalid;
  assign m_axil_wvalid  = r_wvalid;
  assign m_axil_arvalid = r_arvalid;
  assign m_axil_wdata   = r_wdata;
  assign m_axil_wstrb   = r_wstrb;
  assign m_axil_bready  = (r_state == WRITE);
  assign m_axil_rready  = (r_state == READ);

  assign resp_valid = (r_state == DONE);
  assign resp_err   = resp_valid && r_err;
  assign resp_rdata = (resp_valid && !r_we) ? r_rdata : '0;

endmodule

// File: tb/tb_axil_master_bridge.sv
// Directed bench for axil_master_bridge: a small AXI-Lite RAM and scripted
// slave responses, driven cycle by cycle with hand-computed expectations.
module tb_axil_master_bridge;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr, m_axil_rdata;
  logic [2:0]  m_axil_awprot, m_axil_arprot;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic [1:0]  m_axil_bresp, m_axil_rresp;
  logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
  logic        m_axil_rvalid, m_axil_rready;

  logic [31:0] mem [0:63];
  int          n_checks = 0;
  int          n_errors = 0;

  axil_master_bridge dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    m_axil_awready = 1'b0; m_axil_wready = 1'b0;
    m_axil_bvalid  = 1'b0; m_axil_bresp  = 2'b00;
    m_axil_arready = 1'b0; m_axil_rvalid = 1'b0;
    m_axil_rdata   = '0;   m_axil_rresp  = 2'b00;
  endtask

  // Ready and response together, as a registering slave would give them.
  task automatic slave_respond(input logic we, input logic [31:0] rdata, input logic [1:0] resp);
    if (we) begin
      m_axil_awready = 1'b1; m_axil_wready = 1'b1;
      m_axil_bvalid  = 1'b1; m_axil_bresp  = resp;
    end else begin
      m_axil_arready = 1'b1; m_axil_rvalid = 1'b1;
      m_axil_rdata   = rdata; m_axil_rresp = resp;
    end
  endtask

  // Presents a request in the current cycle N; returns in cycle N+1.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    tick();
    req_valid = 1'b0;
  endtask

  // Full transaction against the RAM model with registered ready/response.
  task automatic ram_txn(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input logic [31:0] exp_rdata);
    logic [31:0] a, d;
    logic [3:0]  s;
    issue(we, addr, wdata, wstrb);
    check({tag, ".valids_n1"}, {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid},
          we ? 3'b110 : 3'b001);
    a = we ? m_axil_awaddr : m_axil_araddr;
    d = m_axil_wdata;
    s = m_axil_wstrb;
    check({tag, ".addr"}, a, addr);
    tick();
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
      slave_respond(1'b1, '0, 2'b00);
    end else begin
      slave_respond(1'b0, mem[a[7:2]], 2'b00);
    end
    check({tag, ".no_resp_n2"}, resp_valid, 1'b0);
    tick();
    slave_idle();
    check({tag, ".resp_n3"}, {resp_valid, resp_err, resp_rdata}, {1'b1, 1'b0, exp_rdata});
    tick();
    check({tag, ".idle_n4"}, {resp_valid, req_ready}, 2'b01);
  endtask

  // Transaction answered with a given response code at N+2.
  task automatic err_txn(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [1:0] resp,
                         input logic [31:0] exp_rdata);
    issue(we, addr, 32'h1234_5678, 4'hF);
    tick();
    slave_respond(we, rdata, resp);
    tick();
    slave_idle();
    check({tag, ".resp"}, {resp_valid, resp_err, resp_rdata}, {1'b1, 1'b1, exp_rdata});
    tick();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
    slave_idle();

    // Reset state
    repeat (3) tick();
    check("rst.req_ready", req_ready, 1'b0);
    check("rst.resp", {resp_valid, resp_err, resp_rdata}, 34'h0);
    check("rst.valids", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}, 3'b000);
    check("rst.readies", {m_axil_bready, m_axil_rready}, 2'b00);
    check("rst.aw_ar", {m_axil_awaddr, m_axil_araddr}, 64'h0);
    check("rst.w", {m_axil_wdata, m_axil_wstrb}, 36'h0);
    rstn = 1'b1;
    #1;
    check("rst.ready_after", req_ready, 1'b1);
    check("rst.prot", {m_axil_awprot, m_axil_arprot}, 6'b000_000);
    tick();

    // Full write then read back, back to back
    ram_txn("wr10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0);
    ram_txn("rd10", 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF);

    // Partial strobe merge
    ram_txn("wr20a", 1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0);
    ram_txn("wr20b", 1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 32'h0);
    ram_txn("rd20", 1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'h11BB_33DD);

    // Split handshakes: awready at N+2, wready at N+5, bvalid at N+6
    issue(1'b1, 32'h0000_000C, 32'hCAFE_F00D, 4'hC);
    check("split.n1_valids", {m_axil_awvalid, m_axil_wvalid, req_ready}, 3'b110);
    check("split.n1_data", {m_axil_awaddr, m_axil_wdata, m_axil_wstrb},
          {32'h0000_000C, 32'hCAFE_F00D, 4'hC});
    tick();
    m_axil_awready = 1'b1;
    check("split.n2", {m_axil_awvalid, m_axil_wvalid, req_ready}, 3'b110);
    tick();
    m_axil_awready = 1'b0;
    check("split.n3", {m_axil_awvalid, m_axil_wvalid, req_ready}, 3'b010);
    tick();
    check("split.n4", {m_axil_awvalid, m_axil_wvalid, req_ready, m_axil_wdata},
          {3'b010, 32'hCAFE_F00D});
    tick();
    m_axil_wready = 1'b1;
    check("split.n5", {m_axil_awvalid, m_axil_wvalid, req_ready, m_axil_bready}, 4'b0101);
    tick();
    m_axil_wready = 1'b0;
    m_axil_bvalid = 1'b1;
    check("split.n6", {m_axil_awvalid, m_axil_wvalid, req_ready, resp_valid}, 4'b0000);
    tick();
    m_axil_bvalid = 1'b0;
    check("split.n7_resp", {resp_valid, resp_err, resp_rdata, req_ready}, {2'b10, 32'h0, 1'b0});
    tick();
    check("split.n8_idle", {resp_valid, req_ready}, 2'b01);

    // Error responses
    err_txn("rd_slverr", 1'b0, 32'h0000_0040, 32'h0BAD_F00D, 2'b10, 32'h0BAD_F00D);
    err_txn("wr_decerr", 1'b1, 32'h0000_0044, 32'h0, 2'b11, 32'h0);

    // Backpressure: arready low for 10 cycles while the core pokes req_valid
    issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("stall.c%0d_ar", i), {m_axil_arvalid, m_axil_araddr, req_ready},
            {1'b1, 32'h0000_0010, 1'b0});
      check($sformatf("stall.c%0d_aw", i), {m_axil_awvalid, m_axil_wvalid, resp_valid}, 3'b000);
      req_valid = i[0];
      req_we = 1'b1; req_addr = 32'h0000_0099; req_wdata = 32'hFFFF_FFFF; req_wstrb = 4'hF;
      tick();
    end
    req_valid = 1'b0;
    check("stall.ar_after", {m_axil_arvalid, m_axil_araddr}, {1'b1, 32'h0000_0010});
    slave_respond(1'b0, mem[4], 2'b00);
    tick();
    slave_idle();
    check("stall.resp", {resp_valid, resp_err, resp_rdata}, {2'b10, 32'hDEAD_BEEF});
    tick();
    check("stall.no_extra", {req_ready, m_axil_awvalid, m_axil_arvalid, resp_valid}, 4'b1000);

    // Unsolicited responses in IDLE are not handshaken
    m_axil_bvalid = 1'b1; m_axil_rvalid = 1'b1;
    #1;
    check("unsol.readies", {m_axil_bready, m_axil_rready}, 2'b00);
    tick();
    check("unsol.no_resp", {resp_valid, req_ready}, 2'b01);
    slave_idle();

    // Reset in the middle of a write
    issue(1'b1, 32'h0000_0050, 32'h5555_AAAA, 4'hF);
    check("rstmid.n1", {m_axil_awvalid, m_axil_wvalid}, 2'b11);
    rstn = 1'b0;
    tick();
    check("rstmid.cleared", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid,
                             m_axil_bready, m_axil_rready, resp_valid}, 6'b0);
    rstn = 1'b1;
    #1;
    check("rstmid.ready", req_ready, 1'b1);
    ram_txn("rstmid.rd20", 1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'h11BB_33DD);
    check("rstmid.mem50", mem[20], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axil_master_bridge.md
# axil_master_bridge

Converts the core's single-outstanding load/store request port into AXI4-Lite master transactions. It sits between the core's memory stage and the AXI4-Lite interconnect or RAM slave. It issues exactly one read or write at a time, drives the AW, W, B, AR and R channels, and returns read data and an error flag to the core.

## Interface
- DATA_WIDTH, 32, data bus width in bits
- ADDR_WIDTH, 32, address bus width in bits
- STRB_WIDTH, DATA_WIDTH/8, write-strobe width
- PROT, 3'b000, constant value driven on m_axil_awprot and m_axil_arprot

Reset: rstn, synchronous, active-low. Clock: clk.

- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  bridge can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  byte address, passed to AXI unmodified
- req_wdata  in  DATA_WIDTH  write data
- req_wstrb  in  STRB_WIDTH  byte enables; ignored for reads
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_WIDTH  read data; 0 after writes
- resp_err  out  1  bit 1 of the bresp or rresp that completed the request
- m_axil_awaddr, m_axil_awprot, m_axil_awvalid  out  ADDR_WIDTH / 3 / 1  write address channel
- m_axil_awready  in  1
- m_axil_wdata, m_axil_wstrb, m_axil_wvalid  out  DATA_WIDTH / STRB_WIDTH / 1  write data channel
- m_axil_wready  in  1
- m_axil_bresp  in  2;  m_axil_bvalid  in  1;  m_axil_bready  out  1
- m_axil_araddr, m_axil_arprot, m_axil_arvalid  out  ADDR_WIDTH / 3 / 1
- m_axil_arready  in  1
- m_axil_rdata  in  DATA_WIDTH;  m_axil_rresp  in  2;  m_axil_rvalid  in  1;  m_axil_rready  out  1

## Operation
- The FSM has four states: IDLE, WRITE, READ, DONE.
- In IDLE, req_ready = 1. All other states drive req_ready = 0.
- On req_valid && req_ready, the bridge latches addr, wdata, wstrb and we into registers. It then moves to WRITE if we = 1, else to READ.
- Entering WRITE sets awvalid = 1 and wvalid = 1 (both registered) and clears the flags aw_done and w_done.
  - awvalid drops the cycle after awvalid && awready, and aw_done is set.
  - wvalid drops the cycle after wvalid && wready, and w_done is set.
  - AW and W complete in either order or in the same cycle.
- bready = 1 for the whole of WRITE.
- B handshake (bvalid && bready) captures bresp and moves to DONE. This holds even when the B handshake coincides with the AW or W handshake: B may arrive in the same cycle as awready and wready.
- Entering READ sets arvalid = 1. arvalid drops the cycle after arvalid && arready. rready = 1 for the whole of READ.
- R handshake captures rdata and rresp and moves to DONE. R arriving in the same cycle as arready is legal.
- In DONE, resp_valid = 1 for exactly one cycle, then the FSM returns to IDLE.
  - resp_rdata is the captured rdata for reads and 0 for writes.
  - resp_err is resp[1], so SLVERR and DECERR both flag an error.
- AXI outputs hold stable while valid is asserted and not yet accepted.
- Addresses are not realigned.
- The bridge has no timeout and no request queue.
- Responses that arrive unsolicited (bvalid outside WRITE, rvalid outside READ) are not handshaken, because bready and rready are 0.

## Timing
- Reset values:
  - req_ready = 0 during reset, then 1 in IDLE.
  - resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - awvalid = wvalid = arvalid = 0.
  - bready = rready = 0.
  - awaddr, araddr, wdata, wstrb = 0.
- Request accepted at cycle N:
  - The first valid on the AXI channel is asserted at N+1.
  - A B or R handshake at cycle M gives resp_valid at M+1.
  - The next request can be accepted at M+2.
- Against a slave that registers ready and response together (ready and response at N+2):
  - Read: resp_valid at N+3, throughput one request per 4 cycles.
  - Write: same latency and throughput as a read.
- Reset mid-transaction: on the next edge the FSM returns to IDLE, all valids and readies drop, resp_valid = 0, and the pending request is abandoned with no response.
- req_valid asserted while req_ready = 0 is ignored. The core holds it until accepted.

## Test plan
- Write: addr 0x0000_0010, wdata 0xDEADBEEF, wstrb 4'hF to the team AXI-Lite RAM. Required: awvalid and wvalid at N+1, resp_valid pulse at N+3 with resp_err = 0, resp_rdata = 0. A following read of 0x10 returns 0xDEADBEEF at resp_valid.
- Partial strobe: write 0x11223344 to 0x20 with 4'hF, then 0xAABBCCDD with wstrb 4'b0101. A read of 0x20 returns 0x11BB33DD.
- Split handshakes: a slave model asserts awready at N+2, wready at N+5 and bvalid at N+6. Required: awvalid low from N+3, wvalid held until N+5 then low from N+6, resp_valid at N+7, req_ready = 0 throughout.
- Error: a slave returns rresp = 2'b10 with rdata 0x0BADF00D. Required: resp_err = 1 and resp_rdata = 0x0BADF00D. Repeat for a write with bresp = 2'b11 and require resp_err = 1.
- Backpressure and stability: arready held low for 10 cycles. Required: arvalid and araddr constant throughout, and req_valid pulses during the stall are not accepted.
- Reset mid-write: assert rstn = 0 at N+1. Required: all valids 0 and resp_valid = 0 on the next edge, req_ready = 1 on the first cycle after reset releases, and a new read completes normally.
